// File: rtl/seq_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle, MSB chunk first.
// Define SEQ_COMP_EARLY_EXIT_EN to stop at the first differing chunk; otherwise latency is constant.
module seq_comparator #(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             equal,
  output logic             less,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              sgn_q;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic              found, found_gt;

  logic [CHUNK-1:0]  ca, cb;
  logic              diff, cgt, last, hit, rgt, finish;

  always_comb begin
    ca = a_q[int'(idx)*CHUNK +: CHUNK];
    cb = b_q[int'(idx)*CHUNK +: CHUNK];
    // Offset-binary trick: flipping the sign bits turns a signed top chunk into an unsigned compare.
    if (sgn_q && idx == IW'(NCHUNK - 1)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    diff = (ca != cb);
    cgt  = (ca > cb);
    last = (idx == '0);
    // The most significant differing chunk decides; later chunks never override it.
    hit  = found | diff;
    rgt  = found ? found_gt : cgt;
`ifdef SEQ_COMP_EARLY_EXIT_EN
    finish = diff | last;
`else
    finish = last;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      found    <= 1'b0;
      found_gt <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      greater  <= 1'b0;
      equal    <= 1'b0;
      less     <= 1'b0;
      cycles   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            sgn_q    <= signed_mode;
            idx      <= IW'(NCHUNK - 1);
            cnt      <= '0;
            found    <= 1'b0;
            found_gt <= 1'b0;
            busy     <= 1'b1;
            state    <= CMP;
          end
        end
        CMP: begin
          cnt <= cnt + CW'(1);
          if (!found && diff) begin
            found    <= 1'b1;
            found_gt <= cgt;
          end
          if (finish) begin
            state   <= DONE;
            done    <= 1'b1;
            greater <= hit & rgt;
            less    <= hit & ~rgt;
            equal   <= ~hit;
            cycles  <= cnt + CW'(1);
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator (WIDTH=32, CHUNK=8); expectations follow SEQ_COMP_EARLY_EXIT_EN.
module tb_seq_comparator;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int LIMIT  = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             busy, done, greater, equal, less;
  logic [CW-1:0]    cycles;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] res;   // {greater, equal, less}
    int         cyc;
    int         lat;   // cycle index of the done pulse, accept edge = 0
  } exp_t;

  exp_t       sb[$];
  logic [2:0] last_res;

  seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy), .done(done), .greater(greater),
    .equal(equal), .less(less), .cycles(cycles)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    exp_t e;
    logic gt, lt;
    int   first;
    logic [WIDTH-1:0] x;
    gt = s ? ($signed(a) > $signed(b)) : (a > b);
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    e.res = {gt, !(gt || lt), lt};
    first = -1;
    x = a ^ b;
    for (int i = 0; i < NCHUNK; i++)
      if (first < 0 && x[WIDTH-1-i*CHUNK -: CHUNK] != '0) first = i;
    e.cyc = NCHUNK;
`ifdef SEQ_COMP_EARLY_EXIT_EN
    if (first >= 0) e.cyc = first + 1;
`endif
    e.lat = e.cyc + 1;
    return e;
  endfunction

  // Called at a negedge while idle; returns at the negedge of the cycle after done.
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         output exp_t o, output int busy_n, output logic [2:0] held,
                         output logic [4:0] post);
    int lat;
    sb.push_back(model(a, b, s));
    A = a; B = b; signed_mode = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    held = {greater, equal, less};
    lat = 1;
    busy_n = 0;
    while (lat <= LIMIT) begin
      if (busy) busy_n++;
      if (done) break;
      @(negedge clk);
      lat++;
    end
    o.res = {greater, equal, less};
    o.cyc = int'(cycles);
    o.lat = lat;
    @(negedge clk);
    post = {busy, done, greater, equal, less};
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #11;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_busy_done: got=%b exp=00", {busy, done});
    end
    checks++;
    if ({greater, equal, less} !== 3'b000) begin
      failures++;
      $display("FAIL reset_results: got=%b exp=000", {greater, equal, less});
    end
    checks++;
    if (cycles !== '0) begin
      failures++;
      $display("FAIL reset_cycles: got=%0d exp=0", cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_compare_table;
    logic [WIDTH-1:0] ta[$], tb_[$];
    logic             ts[$];
    exp_t             o, e;
    int               busy_n, k;
    logic [2:0]       held;
    logic [4:0]       post;
    logic [WIDTH-1:0] a, b;
    ta = '{32'h12345678, 32'hC8000000, 32'hC8000000, 32'h00000000, 32'h00000000,
           32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tb_ = '{32'h12345678, 32'h64000000, 32'h64000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h00000100, 32'h00000000, 32'h00000000};
    ts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = a;
      k = $urandom_range(0, NCHUNK);
      if (k < NCHUNK) b[k*CHUNK +: CHUNK] = CHUNK'($urandom);
      ta.push_back(a); tb_.push_back(b); ts.push_back(1'($urandom));
    end
    for (int i = 0; i < ta.size(); i++) begin
      run_cmp(ta[i], tb_[i], ts[i], o, busy_n, held, post);
      e = sb.pop_front();
      checks++;
      if (o.res !== e.res) begin
        failures++;
        $display("FAIL cmp%0d_result: a=%h b=%h s=%b got=%b exp=%b", i, ta[i], tb_[i], ts[i], o.res, e.res);
      end
      checks++;
      if (o.cyc != e.cyc) begin
        failures++;
        $display("FAIL cmp%0d_cycles: got=%0d exp=%0d", i, o.cyc, e.cyc);
      end
      checks++;
      if (o.lat != e.lat) begin
        failures++;
        $display("FAIL cmp%0d_done_cycle: got=%0d exp=%0d", i, o.lat, e.lat);
      end
      checks++;
      if (busy_n != e.lat) begin
        failures++;
        $display("FAIL cmp%0d_busy_cycles: got=%0d exp=%0d", i, busy_n, e.lat);
      end
      checks++;
      if (held !== last_res) begin
        failures++;
        $display("FAIL cmp%0d_held_on_accept: got=%b exp=%b", i, held, last_res);
      end
      checks++;
      if (post !== {2'b00, e.res}) begin
        failures++;
        $display("FAIL cmp%0d_after_done: got=%b exp=%b", i, post, {2'b00, e.res});
      end
      last_res = e.res;
    end
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    int   lat, extra;
    sb.push_back(model(32'd5, 32'd3, 1'b0));
    A = 32'd5; B = 32'd3; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 32'd1; B = 32'd9;
    lat = 1;
    while (lat <= LIMIT) begin
      if (done) break;
      @(negedge clk);
      lat++;
      start = 1'b0;
      A = $urandom; B = $urandom; signed_mode = 1'($urandom);
    end
    e = sb.pop_front();
    checks++;
    if ({greater, equal, less} !== e.res || lat != e.lat) begin
      failures++;
      $display("FAIL busy_ignore_result: got=%b@%0d exp=%b@%0d", {greater, equal, less}, lat, e.res, e.lat);
    end
    checks++;
    if (int'(cycles) != e.cyc) begin
      failures++;
      $display("FAIL busy_ignore_cycles: got=%0d exp=%0d", cycles, e.cyc);
    end
    extra = 0;
    start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_ignore_second_done: got=%0d exp=0", extra);
    end
    checks++;
    if ({greater, equal, less} !== e.res) begin
      failures++;
      $display("FAIL busy_ignore_hold: got=%b exp=%b", {greater, equal, less}, e.res);
    end
    last_res = e.res;
  endtask

  task automatic test_reset_mid;
    exp_t       o, e;
    int         busy_n, bad;
    logic [2:0] held;
    logic [4:0] post;
    A = 32'h5A5A5A5A; B = 32'h5A5A5A5A; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, greater, equal, less} !== 5'b0 || cycles !== '0) begin
      failures++;
      $display("FAIL reset_mid_clear: got=%b/%0d exp=00000/0", {busy, done, greater, equal, less}, cycles);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got=%0d exp=0", bad);
    end
    last_res = 3'b000;
    run_cmp('0, '0, 1'b0, o, busy_n, held, post);
    e = sb.pop_front();
    checks++;
    if (o.res !== 3'b010 || o.res !== e.res) begin
      failures++;
      $display("FAIL reset_mid_restart_result: got=%b exp=010", o.res);
    end
    checks++;
    if (o.cyc != NCHUNK || o.lat != NCHUNK + 1) begin
      failures++;
      $display("FAIL reset_mid_restart_cycles: got=%0d@%0d exp=%0d@%0d", o.cyc, o.lat, NCHUNK, NCHUNK + 1);
    end
    checks++;
    if (held !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_held: got=%b exp=000", held);
    end
  endtask

  initial begin
    test_reset;
    test_compare_table;
    test_busy_ignore;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_comparator.md
Name: seq_comparator

Overview:
Parametrised multi-cycle magnitude comparator; successor to the 8-bit combinational comparator. Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, in unsigned or two's-complement signed mode, with start/busy/done handshake. Used where wide operands make a single-cycle compare too slow, or where constant-time comparison is required.

Parameters:
WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK
CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH
NCHUNK, WIDTH/CHUNK, derived localparam; number of chunks
CW, $clog2(NCHUNK+1), derived localparam; width of the cycles output

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only in IDLE
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched on accept
A  input  WIDTH  operand A; latched on accept
B  input  WIDTH  operand B; latched on accept
busy  output  1  high in CMP and DONE states
done  output  1  one-cycle pulse; results valid
greater  output  1  A > B
equal  output  1  A == B
less  output  1  A < B
cycles  output  CW  number of CMP cycles used by the last compare

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, greater, equal, less and cycles all 0. Latched operands cleared. Takes effect immediately, including mid-compare; the in-flight compare is discarded.
- FSM states: IDLE, CMP, DONE.
- IDLE: start=1 at a rising edge -> latch A, B and signed_mode; idx=NCHUNK-1; cycle count=0; go to CMP.
- CMP, one cycle per chunk: compare latched chunk idx of A and B.
  - Signed mode, top chunk only: invert the MSB of both chunks before an unsigned compare (offset binary). Lower chunks are always compared unsigned.
  - Chunks differ -> record greater/less and go to DONE.
  - Chunks equal and idx==0 -> record equal and go to DONE.
  - Otherwise decrement idx.
  - The cycle count increments on every CMP cycle.
- DONE: lasts one cycle. done=1. greater/equal/less/cycles are updated and visible in this cycle. Next state is IDLE.
- Timing: start sampled at edge 0 -> CMP occupies cycles 1..k -> done is high in cycle k+1. busy is high for cycles 1..k+1. The earliest next accept is the edge ending cycle k+1 + 1 (IDLE).
- Result outputs hold their value from the DONE cycle until the next DONE or reset. They are not cleared on accept.
- Exactly one of greater/equal/less is high after the first completed compare. All three are 0 only between reset and the first done.
- start while busy=1 is ignored, not queued. Changes on A, B or signed_mode while busy do not affect the result.
- NCHUNK=1 is legal: k=1 always.

Optional Feature:
Macro SEQ_COMP_EARLY_EXIT_EN.
- Defined: CMP stops at the first differing chunk, as described above. cycles is between 1 and NCHUNK.
- Undefined: CMP always scans all NCHUNK chunks (constant latency). The result is taken from the first (most significant) differing chunk; later chunks do not overwrite it. If all chunks are equal, equal=1. cycles is always NCHUNK, and done is always in cycle NCHUNK+1.

Test Plan:
All cases use WIDTH=32, CHUNK=8, macro defined unless stated.
1. A=B=0x12345678, unsigned, start pulse -> done in cycle 5, equal=1, greater=less=0, cycles=4, busy high for cycles 1-5.
2. A=0xC8000000, B=0x64000000, unsigned -> greater=1, cycles=1, done in cycle 2. Same stimulus with the macro undefined -> greater=1, cycles=4, done in cycle 5.
3. Same operands as case 2, signed_mode=1 -> less=1 (A is negative). A=0x00000000, B=0xFFFFFFFF, signed -> greater=1, cycles=1. Same operands, unsigned -> less=1.
4. A=0x000000FF, B=0x00000100, unsigned -> less=1, cycles=3. A=0xFFFFFFFF, B=0x00000000: unsigned -> greater=1; signed -> less=1.
5. Start A=5, B=3 (unsigned). While busy, pulse start again with A=1, B=9 and change A/B every cycle -> second start ignored; result greater=1; no second done.
6. Assert rst_n=0 during CMP of a 4-chunk equal compare -> busy, done, results and cycles go to 0 immediately, with no done pulse. Release reset, start A=B=0 -> equal=1, cycles=4.
